// File: rtl/hist_ckpt_pkg.sv
// Shared defaults and pointer/tag types for the history checkpoint controller.
package hist_ckpt_pkg;

    localparam int HIST_W_DEF = 32;
    localparam int DEPTH_DEF  = 8;
    localparam int TAG_W      = $clog2(DEPTH_DEF);

    // Checkpoint index, and queue pointer carrying one extra wrap bit.
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [TAG_W:0]   ptr_t;

endpackage

// File: rtl/hist_ckpt_ram.sv
// Checkpoint storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; only live entries are ever read back.
module hist_ckpt_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // Capture the pre-update history of each accepted prediction.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hist_ckpt_ctrl.sv
// Speculative global-history tracker with per-branch checkpoints.
// Predictions shift the history and push a checkpoint; a mispredict on a
// live tag restores from that checkpoint and flushes all younger entries.
// Optional build macro HIST_CKPT_STATS_EN adds a saturating mispredict_count.
module hist_ckpt_ctrl
    import hist_ckpt_pkg::*;
#(
    parameter int HIST_W = HIST_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     predict_valid,
    input  logic                     predict_taken,
    output logic                     predict_ready,
    output logic [$clog2(DEPTH)-1:0] predict_tag,
    input  logic                     retire_valid,
    input  logic                     train_mispredicted,
    input  logic                     train_taken,
    input  logic [$clog2(DEPTH)-1:0] train_tag,
    output logic [HIST_W-1:0]        predict_history,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full,
    output logic                     empty
`ifdef HIST_CKPT_STATS_EN
    ,
    output logic [15:0]              mispredict_count
`endif
);

    localparam int            IW      = $clog2(DEPTH);
    localparam logic [IW:0]   PTR_ONE = (IW+1)'(1);
    localparam logic [IW:0]   DEPTH_P = (IW+1)'(DEPTH);

    logic [IW:0]       head_q, tail_q, occ, tag_pos;
    logic [IW-1:0]     rel;
    logic [HIST_W-1:0] hist_q, ckpt_rd;
    logic              accept, retire, live, restore;

    assign occ             = tail_q - head_q;
    assign occupancy       = occ;
    assign full            = (occ == DEPTH_P);
    assign empty           = (occ == '0);
    assign predict_history = hist_q;

    // Mispredict owns the cycle, so a same-cycle predict is refused.
    assign predict_ready = !full && !train_mispredicted;
    assign predict_tag   = tail_q[IW-1:0];
    assign accept        = predict_valid && predict_ready;
    assign retire        = retire_valid && !empty;

    // A tag is live when its distance from head lies inside the occupied window.
    assign rel     = train_tag - head_q[IW-1:0];
    assign live    = ({1'b0, rel} < occ);
    assign restore = train_mispredicted && live;
    assign tag_pos = head_q + {1'b0, rel};

    hist_ckpt_ram #(
        .W     (HIST_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (tail_q[IW-1:0]),
        .wdata (hist_q),
        .raddr (train_tag),
        .rdata (ckpt_rd)
    );

    // Pointer and history update; retire composes with either restore or predict.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            hist_q <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (retire) head_q <= head_q + PTR_ONE;
            if (restore) begin
                hist_q <= {ckpt_rd[HIST_W-2:0], train_taken};
                tail_q <= tag_pos + PTR_ONE;
            end else if (accept) begin
                hist_q <= {hist_q[HIST_W-2:0], predict_taken};
                tail_q <= tail_q + PTR_ONE;
            end
        end
    end

`ifdef HIST_CKPT_STATS_EN
    // Count applied restores, saturating at all-ones.
    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            mispredict_count <= '0;
        else if (restore && (mispredict_count != 16'hFFFF))
            mispredict_count <= mispredict_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_hist_ckpt_ctrl.sv
// Self-checking bench for hist_ckpt_ctrl: directed vector table, hand-written
// corner sequences, and a randomized run against a queue-based reference model.
module tb_hist_ckpt_ctrl;

    localparam int HW = 32;
    localparam int D  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          areset;
    logic          predict_valid, predict_taken, retire_valid;
    logic          train_mispredicted, train_taken;
    logic [IW-1:0] train_tag;
    logic          predict_ready;
    logic [IW-1:0] predict_tag;
    logic [HW-1:0] predict_history;
    logic [IW:0]   occupancy;
    logic          full, empty;
`ifdef HIST_CKPT_STATS_EN
    logic [15:0]   mispredict_count;
`endif

    int checks   = 0;
    int failures = 0;

    hist_ckpt_ctrl dut (
        .clk                (clk),
        .areset             (areset),
        .predict_valid      (predict_valid),
        .predict_taken      (predict_taken),
        .predict_ready      (predict_ready),
        .predict_tag        (predict_tag),
        .retire_valid       (retire_valid),
        .train_mispredicted (train_mispredicted),
        .train_taken        (train_taken),
        .train_tag          (train_tag),
        .predict_history    (predict_history),
        .occupancy          (occupancy),
        .full               (full),
        .empty              (empty)
`ifdef HIST_CKPT_STATS_EN
        ,
        .mispredict_count   (mispredict_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_cnt(input string nm, input int exp);
`ifdef HIST_CKPT_STATS_EN
        chk(nm, 64'(mispredict_count), 64'(exp));
`endif
    endtask

    task automatic drive(input bit pv, input bit pt, input bit rv,
                         input bit tm, input bit tt, input int tag);
        @(negedge clk);
        predict_valid      = pv;
        predict_taken      = pt;
        retire_valid       = rv;
        train_mispredicted = tm;
        train_taken        = tt;
        train_tag          = IW'(tag);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1;
        predict_valid = 0; predict_taken = 0; retire_valid = 0;
        train_mispredicted = 0; train_taken = 0; train_tag = '0;
        @(negedge clk);
        chk("rst_hist", 64'(predict_history), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_tag", 64'(predict_tag), 64'd0);
        chk_cnt("rst_cnt", 0);
        areset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit pv, pt, rv, tm, tt;
        int tag;
        bit exp_rdy;
        int exp_ptag;
        int exp_hist;
        int exp_occ;
        int exp_cnt;
    } vec_t;

    function automatic vec_t mk(bit pv, bit pt, bit rv, bit tm, bit tt, int tag,
                                bit rdy, int ptag, int hist, int occ, int cnt);
        vec_t v;
        v.pv = pv; v.pt = pt; v.rv = rv; v.tm = tm; v.tt = tt; v.tag = tag;
        v.exp_rdy = rdy; v.exp_ptag = ptag; v.exp_hist = hist;
        v.exp_occ = occ; v.exp_cnt = cnt;
        return v;
    endfunction

    // ---------------- reference model ----------------
    logic [HW-1:0] mq[$];   // saved histories, oldest first
    int            mhead;   // tag of the oldest live entry
    logic [HW-1:0] mhist;
    int            mcnt;

    task automatic model_reset();
        mq.delete();
        mhead = 0;
        mhist = '0;
        mcnt  = 0;
    endtask

    task automatic model_step(input bit pv, input bit pt, input bit rv,
                              input bit tm, input bit tt, input int tag);
        int sz, rel;
        sz  = mq.size();
        rel = ((tag - mhead) % D + D) % D;
        if (tm && rel < sz) begin
            mhist = {mq[rel][HW-2:0], tt};
            while (mq.size() > rel + 1) void'(mq.pop_back());
            if (mcnt < 16'hFFFF) mcnt++;
        end else if (pv && !tm && sz < D) begin
            mq.push_back(mhist);
            mhist = {mhist[HW-2:0], pt};
        end
        if (rv && sz > 0) begin
            void'(mq.pop_front());
            mhead = (mhead + 1) % D;
        end
    endtask

    initial begin
        vec_t          tbl[10];
        logic [HW-1:0] e;

        areset = 1'b1;
        predict_valid = 0; predict_taken = 0; retire_valid = 0;
        train_mispredicted = 0; train_taken = 0; train_tag = '0;

        // predicts 1,0,1,1; restore on tag 1; dead tag; retire with restore; empty retire
        tbl[0] = mk(1,1,0,0,0,0, 1,0, 'h1, 1,0);
        tbl[1] = mk(1,0,0,0,0,0, 1,1, 'h2, 2,0);
        tbl[2] = mk(1,1,0,0,0,0, 1,2, 'h5, 3,0);
        tbl[3] = mk(1,1,0,0,0,0, 1,3, 'hB, 4,0);
        tbl[4] = mk(1,0,0,1,1,1, 0,0, 'h3, 2,1);
        tbl[5] = mk(1,0,0,0,0,0, 1,2, 'h6, 3,1);
        tbl[6] = mk(0,0,0,1,1,5, 0,0, 'h6, 3,1);
        tbl[7] = mk(0,0,1,0,0,0, 1,3, 'h6, 2,1);
        tbl[8] = mk(0,0,1,1,0,1, 0,0, 'h2, 0,2);
        tbl[9] = mk(0,0,1,0,0,0, 1,2, 'h2, 0,2);

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].pv, tbl[i].pt, tbl[i].rv, tbl[i].tm, tbl[i].tt, tbl[i].tag);
            chk($sformatf("v%0d_rdy", i), 64'(predict_ready), 64'(tbl[i].exp_rdy));
            if (tbl[i].exp_rdy)
                chk($sformatf("v%0d_ptag", i), 64'(predict_tag), 64'(tbl[i].exp_ptag));
            tick();
            chk($sformatf("v%0d_hist", i), 64'(predict_history), 64'(tbl[i].exp_hist));
            chk($sformatf("v%0d_occ", i), 64'(occupancy), 64'(tbl[i].exp_occ));
            chk($sformatf("v%0d_empty", i), 64'(empty), 64'(tbl[i].exp_occ == 0));
            chk_cnt($sformatf("v%0d_cnt", i), tbl[i].exp_cnt);
        end

        // Fill to full, drop 9th, then retire+predict same cycle is refused.
        do_reset();
        e = '0;
        for (int i = 0; i < D; i++) begin
            drive(1, (i % 3) != 1, 0, 0, 0, 0);
            chk("fill_tag", 64'(predict_tag), 64'(i));
            tick();
            e = {e[HW-2:0], 1'((i % 3) != 1)};
        end
        chk("full_flag", 64'(full), 64'd1);
        chk("full_hist", 64'(predict_history), 64'(e));
        drive(1, 1, 0, 0, 0, 0);
        chk("full_rdy", 64'(predict_ready), 64'd0);
        tick();
        chk("drop_hist", 64'(predict_history), 64'(e));
        chk("drop_occ", 64'(occupancy), 64'd8);
        drive(1, 1, 1, 0, 0, 0);
        chk("ret_pred_rdy", 64'(predict_ready), 64'd0);
        tick();
        chk("ret_pred_occ", 64'(occupancy), 64'd7);
        chk("ret_pred_hist", 64'(predict_history), 64'(e));
        drive(1, 1, 0, 0, 0, 0);
        chk("after_rdy", 64'(predict_ready), 64'd1);
        chk("after_tag", 64'(predict_tag), 64'd0);
        tick();
        chk("after_occ", 64'(occupancy), 64'd8);
        chk("after_hist", 64'(predict_history), 64'({e[HW-2:0], 1'b1}));

        // Mispredict on a tag outside the live window.
        do_reset();
        drive(1, 1, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 1, 5); tick();
        chk("dead_hist", 64'(predict_history), 64'h3);
        chk("dead_occ", 64'(occupancy), 64'd2);
        chk("dead_tag", 64'(predict_tag), 64'd2);
        chk_cnt("dead_cnt", 0);

        // Asynchronous reset between edges with live entries.
        do_reset();
        drive(1, 1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 1, 0); tick();
        drive(1, 1, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0); tick();
        chk("pre_ar_occ", 64'(occupancy), 64'd3);
        chk_cnt("pre_ar_cnt", 1);
        drive(0, 0, 0, 0, 0, 0);
        #1 areset = 1'b1;
        #1;
        chk("ar_hist", 64'(predict_history), 64'd0);
        chk("ar_occ", 64'(occupancy), 64'd0);
        chk("ar_empty", 64'(empty), 64'd1);
        chk("ar_full", 64'(full), 64'd0);
        chk_cnt("ar_cnt", 0);
        @(negedge clk);
        areset = 1'b0;

        // Randomized run against the queue model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit pv, pt, rv, tm, tt;
            int tag, sz;
            bit erdy;
            pv  = ($urandom_range(0, 3) != 0);
            pt  = 1'($urandom);
            rv  = ($urandom_range(0, 2) == 0);
            tm  = ($urandom_range(0, 9) == 0);
            tt  = 1'($urandom);
            tag = $urandom_range(0, D - 1);
            drive(pv, pt, rv, tm, tt, tag);
            sz   = mq.size();
            erdy = (sz < D) && !tm;
            chk("rnd_rdy", 64'(predict_ready), 64'(erdy));
            if (erdy) chk("rnd_tag", 64'(predict_tag), 64'((mhead + sz) % D));
            model_step(pv, pt, rv, tm, tt, tag);
            tick();
            chk("rnd_hist", 64'(predict_history), 64'(mhist));
            chk("rnd_occ", 64'(occupancy), 64'(mq.size()));
            chk("rnd_full", 64'(full), 64'(mq.size() == D));
            chk("rnd_empty", 64'(empty), 64'(mq.size() == 0));
            chk_cnt("rnd_cnt", mcnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hist_ckpt_ctrl.md
HIST_CKPT_CTRL -- requirements
Module: hist_ckpt_ctrl

Interface
REQ-001 SHALL have parameter HIST_W, default 32, meaning global history width.
REQ-002 SHALL have parameter DEPTH, default 8, meaning checkpoint entries; power of two, 2..64.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port areset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port predict_valid  in  1  new predicted branch this cycle.
REQ-006 SHALL have port predict_taken  in  1  predicted direction.
REQ-007 SHALL have port predict_ready  out  1  prediction accepted when valid&&ready.
REQ-008 SHALL have port predict_tag  out  log2(DEPTH)  checkpoint tag assigned to an accepted prediction.
REQ-009 SHALL have port retire_valid  in  1  oldest live branch resolved; free its entry.
REQ-010 SHALL have port train_mispredicted  in  1  misprediction on branch train_tag.
REQ-011 SHALL have port train_taken  in  1  actual direction of mispredicted branch.
REQ-012 SHALL have port train_tag  in  log2(DEPTH)  tag of mispredicted branch.
REQ-013 SHALL have port predict_history  out  HIST_W  speculative global history, bit 0 youngest.
REQ-014 SHALL have port occupancy  out  log2(DEPTH)+1  live checkpoint count.
REQ-015 SHALL have ports full and empty  out  1 each  occupancy==DEPTH / ==0.

Function
REQ-016 SHALL keep head/tail pointers with one extra wrap bit; occupancy = tail-head.
REQ-017 SHALL drive predict_ready = !full && !train_mispredicted (combinational).
REQ-018 SHALL, on accepted predict: write checkpoint[tail] = pre-update history; history <= {history[HIST_W-2:0], predict_taken}; tail++.
REQ-019 SHALL drive predict_tag = tail[index bits] combinationally; valid only while predict_ready.
REQ-020 SHALL, on retire_valid with occupancy>0, increment head; retire_valid when empty SHALL be ignored.
REQ-021 SHALL treat train_tag as live iff ((train_tag-head) mod DEPTH) < occupancy.
REQ-022 SHALL, on train_mispredicted with live tag: history <= {checkpoint[train_tag][HIST_W-2:0], train_taken}; tail <= tag-entry position+1 (younger entries flushed, mispredicted entry stays live until retired).
REQ-023 SHALL ignore train_mispredicted with a non-live tag (no state change).
REQ-024 SHALL give mispredict priority over predict; a same-cycle predict is not accepted (ready low).
REQ-025 SHALL apply same-cycle retire and mispredict together (head++, tail recomputed); if retired entry equals train_tag, restore still occurs and occupancy becomes 0.
REQ-026 SHALL not bypass a same-cycle retire into predict_ready when full.
REQ-027 SHALL update all state in one cycle; new history visible the cycle after the triggering edge.

Reset
REQ-028 SHALL on areset assert: predict_history=0, head=tail=0, occupancy=0, empty=1, full=0, independent of clk.
REQ-029 SHALL leave checkpoint storage contents unreset; non-live entries never observable.
REQ-030 SHALL treat reset mid-operation as discarding all live checkpoints.

Configuration
REQ-031 SHALL, with HIST_CKPT_STATS_EN defined, add output mispredict_count (16 bits, reset 0, +1 per applied restore of REQ-022, saturating at 0xFFFF).
REQ-032 SHALL, without HIST_CKPT_STATS_EN, omit the port and counter entirely.

Structure
REQ-033 SHALL place HIST_W/DEPTH defaults, tag_t and ptr_t typedefs in package hist_ckpt_pkg.
REQ-034 SHALL implement checkpoint storage as sub-module hist_ckpt_ram (1 write port, 1 asynchronous read port indexed by train_tag).

Verification
REQ-035 SHALL check: reset, 4 predicts taken=1,0,1,1 -> history 0x0000000B, tags 0..3, occupancy 4.
REQ-036 SHALL check: after REQ-035, mispredict tag=1 taken=1 -> history 0x00000003, occupancy 2, next predict_tag 2.
REQ-037 SHALL check: 8 predicts without retire -> full=1, predict_ready=0, 9th predict dropped, history unchanged.
REQ-038 SHALL check: full, retire+predict same cycle -> predict rejected, occupancy 7; next cycle accepted, tag 0.
REQ-039 SHALL check: mispredict with tag outside live window (e.g. tag 5, occupancy 2, head 0) -> no change, counter unchanged.
REQ-040 SHALL check: areset asserted between clock edges with occupancy 3 -> outputs zero immediately; with HIST_CKPT_STATS_EN, mispredict_count = 0.
